// File: rtl/riscv_next_pc_predictor.sv
// Static next-PC predictor: JAL taken, backward branches taken, JALR via immediate or return address stack.
// Single registered output stage with valid/ready handshake; the RAS is updated only when an instruction is accepted.
module riscv_next_pc_predictor #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_jal,
  input  logic                  i_jalr,
  input  logic                  i_branch,
  input  logic                  i_rs1_zero,
  input  logic                  i_rs1_ra,
  input  logic                  i_link,
  input  logic                  i_imm_sign,
  input  logic [ADDR_WIDTH-1:0] i_imm,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_next_pc,
  output logic                  o_taken,
  output logic                  o_unknown
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]      ptr;
  logic [CNT_W-1:0]      count;

  logic                  accept;
  logic                  is_jalr;
  logic                  push;
  logic                  pop_hit;
  logic [PTR_W-1:0]      top_idx;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] pred_next;
  logic                  pred_taken;
  logic                  pred_unknown;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  assign seq     = i_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign top_idx = ptr - PTR_W'(1);
  // jal outranks jalr when the decoder raises several flags
  assign is_jalr = i_jalr && !i_jal;
  assign push    = (i_jal || i_jalr) && i_link;
  assign pop_hit = is_jalr && !i_rs1_zero && i_rs1_ra && (count != '0);
  // A simultaneous pop+push replaces the current top in place
  assign wr_idx  = pop_hit ? top_idx : ptr;

  // Target selection, priority jal > jalr > branch
  always_comb begin
    pred_next    = seq;
    pred_taken   = 1'b0;
    pred_unknown = 1'b0;
    if (i_jal) begin
      pred_next  = i_pc + i_imm;
      pred_taken = 1'b1;
    end else if (i_jalr) begin
      if (i_rs1_zero) begin
        pred_next  = {i_imm[ADDR_WIDTH-1:1], 1'b0};
        pred_taken = 1'b1;
      end else if (pop_hit) begin
        pred_next  = ras[top_idx];
        pred_taken = 1'b1;
      end else begin
        pred_unknown = 1'b1;
      end
    end else if (i_branch && i_imm_sign) begin
      pred_next  = i_pc + i_imm;
      pred_taken = 1'b1;
    end
  end

  // RAS pointer/count update
  always_comb begin
    ptr_nxt   = ptr;
    count_nxt = count;
    if (push && !pop_hit) begin
      ptr_nxt = ptr + PTR_W'(1);
      if (count != CNT_W'(RAS_DEPTH)) count_nxt = count + CNT_W'(1);
    end else if (pop_hit && !push) begin
      ptr_nxt   = top_idx;
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras[PTR_W'(i)] <= '0;
    end else if (accept) begin
      ptr   <= ptr_nxt;
      count <= count_nxt;
      if (push) ras[wr_idx] <= seq;
    end
  end

  // Output stage: flush kills, accept loads, consumed data drains
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_pc      <= '0;
      o_next_pc <= '0;
      o_taken   <= 1'b0;
      o_unknown <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_pc      <= i_pc;
      o_next_pc <= pred_next;
      o_taken   <= pred_taken;
      o_unknown <= pred_unknown;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
